// File: rtl/chain_alloc_arbiter.sv
// Arbitrates NUM_PORTS allocation requesters and one release requester onto a shared chain-list allocator.
// Optional: define CHAIN_ARB_FREE_PRIORITY_EN so releases always win over allocations in IDLE.
module chain_alloc_arbiter #(
   parameter int NUM_PORTS = 4,
   parameter int CAPACITY  = 4096
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_PORTS-1:0]   req,
   input  logic [NUM_PORTS*8-1:0] req_size,
   output logic [NUM_PORTS-1:0]   ack,
   output logic [NUM_PORTS-1:0]   nack,
   output logic [11:0]            rsp_addr,
   input  logic                   free_req,
   input  logic [11:0]            free_id,
   input  logic [7:0]             free_size,
   output logic                   free_ack,
   output logic [11:0]            free_addr,
   output logic                   wea,
   output logic [7:0]             w_size,
   input  logic [11:0]            start_write_address,
   output logic                   rea,
   output logic [11:0]            chain_id,
   input  logic [11:0]            start_read_address,
   output logic [12:0]            free_units,
   output logic                   busy
);

   // state   | meaning
   // IDLE    | arbitrate free_req / req
   // ISSUE_A | wea pulse with w_size
   // CAPT_A  | capture start_write_address, debit free_units
   // RESP_A  | schedule ack to granted port
   // ISSUE_F | rea pulse with chain_id
   // CAPT_F  | capture start_read_address, credit free_units
   // RESP_F  | schedule free_ack
   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] ISSUE_A = 3'd1;
   localparam logic [2:0] CAPT_A  = 3'd2;
   localparam logic [2:0] RESP_A  = 3'd3;
   localparam logic [2:0] ISSUE_F = 3'd4;
   localparam logic [2:0] CAPT_F  = 3'd5;
   localparam logic [2:0] RESP_F  = 3'd6;

   localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   logic [2:0]           state;
   logic [PW-1:0]        rr_ptr;
   logic [PW-1:0]        gnt_q;
   logic [7:0]           fsize_q;
   logic [NUM_PORTS-1:0] req_v;
   logic                 free_v;
   logic                 found;
   logic [PW-1:0]        gnt;
   logic [PW-1:0]        gnt_inc;
   logic [PW-1:0]        gnt_q_inc;
   logic [7:0]           gnt_size;
   logic                 reject;
   logic [13:0]          fsum;
   logic [12:0]          fsum_sat;
   logic                 free_sel;

   // A port's own ack/nack cycle still shows its req high; do not re-grant it.
   assign req_v  = req & ~(ack | nack);
   assign free_v = free_req & ~free_ack;

   always_comb begin
      found = 1'b0;
      gnt   = '0;
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
         if (req_v[(int'(rr_ptr) + i) % NUM_PORTS]) begin
            found = 1'b1;
            gnt   = PW'((int'(rr_ptr) + i) % NUM_PORTS);
         end
      end
   end

   always_comb begin
      gnt_size = req_size[int'(gnt)*8 +: 8];
   end

   assign gnt_inc   = (gnt == PW'(NUM_PORTS - 1)) ? '0 : gnt + 1'b1;
   assign gnt_q_inc = (gnt_q == PW'(NUM_PORTS - 1)) ? '0 : gnt_q + 1'b1;
   assign reject    = (gnt_size == 8'd0) || ({5'd0, gnt_size} > free_units);
   assign fsum      = {1'b0, free_units} + {6'd0, fsize_q};
   assign fsum_sat  = (fsum > 14'(CAPACITY)) ? 13'(CAPACITY) : fsum[12:0];
   assign busy      = (state != IDLE);

`ifdef CHAIN_ARB_FREE_PRIORITY_EN
   assign free_sel = free_v;
`else
   logic free_pri;

   // Alternate priority only matters when both kinds are pending together.
   always_ff @(posedge clk) begin
      if (rst) begin
         free_pri <= 1'b1;
      end else if (state == IDLE) begin
         if (free_sel)   free_pri <= 1'b0;
         else if (found) free_pri <= 1'b1;
      end
   end

   assign free_sel = free_v & (free_pri | ~found);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         rr_ptr     <= '0;
         gnt_q      <= '0;
         fsize_q    <= '0;
         ack        <= '0;
         nack       <= '0;
         free_ack   <= 1'b0;
         wea        <= 1'b0;
         rea        <= 1'b0;
         w_size     <= '0;
         chain_id   <= '0;
         rsp_addr   <= '0;
         free_addr  <= '0;
         free_units <= 13'(CAPACITY);
      end else begin
         ack      <= '0;
         nack     <= '0;
         free_ack <= 1'b0;
         wea      <= 1'b0;
         rea      <= 1'b0;
         case (state)
            IDLE: begin
               if (free_sel) begin
                  fsize_q  <= free_size;
                  chain_id <= free_id;
                  rea      <= 1'b1;
                  state    <= ISSUE_F;
               end else if (found) begin
                  if (reject) begin
                     nack   <= NUM_PORTS'(1) << gnt;
                     rr_ptr <= gnt_inc;
                  end else begin
                     gnt_q  <= gnt;
                     w_size <= gnt_size;
                     wea    <= 1'b1;
                     state  <= ISSUE_A;
                  end
               end
            end
            ISSUE_A: state <= CAPT_A;
            CAPT_A: begin
               rsp_addr   <= start_write_address;
               free_units <= free_units - {5'd0, w_size};
               state      <= RESP_A;
            end
            RESP_A: begin
               ack    <= NUM_PORTS'(1) << gnt_q;
               rr_ptr <= gnt_q_inc;
               state  <= IDLE;
            end
            ISSUE_F: state <= CAPT_F;
            CAPT_F: begin
               free_addr  <= start_read_address;
               free_units <= fsum_sat;
               state      <= RESP_F;
            end
            RESP_F: begin
               free_ack <= 1'b1;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_chain_alloc_arbiter.sv
// Scoreboard bench for chain_alloc_arbiter: expected responses queued at stimulus time, popped on ack/nack/free_ack.
module tb_chain_alloc_arbiter;
   localparam int NP = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [NP-1:0] req;
   logic [NP*8-1:0] req_size;
   logic [NP-1:0] ack, nack;
   logic [11:0]   rsp_addr;
   logic          free_req;
   logic [11:0]   free_id;
   logic [7:0]    free_size;
   logic          free_ack;
   logic [11:0]   free_addr;
   logic          wea;
   logic [7:0]    w_size;
   logic [11:0]   swa;
   logic          rea;
   logic [11:0]   chain_id;
   logic [11:0]   sra;
   logic [12:0]   free_units;
   logic          busy;

   chain_alloc_arbiter #(.NUM_PORTS(NP), .CAPACITY(4096)) dut (
      .clk(clk), .rst(rst), .req(req), .req_size(req_size), .ack(ack), .nack(nack),
      .rsp_addr(rsp_addr), .free_req(free_req), .free_id(free_id), .free_size(free_size),
      .free_ack(free_ack), .free_addr(free_addr), .wea(wea), .w_size(w_size),
      .start_write_address(swa), .rea(rea), .chain_id(chain_id),
      .start_read_address(sra), .free_units(free_units), .busy(busy));

   always #5 clk = ~clk;

   // kind: 0 = alloc ack, 1 = nack, 2 = free_ack
   typedef struct {
      int          kind;
      int          port;
      logic [11:0] addr;
      logic [12:0] units;
   } exp_t;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_pass = 0;
   logic [12:0] exp_units;

   function automatic logic [NP*2:0] exp_vec(input int kind, input int port);
      logic [NP-1:0] a, n;
      a = '0;
      n = '0;
      if (kind == 0) a[port] = 1'b1;
      if (kind == 1) n[port] = 1'b1;
      return {a, n, (kind == 2)};
   endfunction

   // Advance until a response appears; lat = -1 if the budget expires.
   task automatic observe(input int budget, output int lat, output int n_wea, output int n_rea,
                          output logic [7:0] wsz, output logic [11:0] cid, output logic both);
      lat = -1; n_wea = 0; n_rea = 0; wsz = '0; cid = '0; both = 1'b0;
      for (int i = 1; i <= budget; i++) begin
         @(negedge clk);
         if (wea) begin n_wea++; wsz = w_size; end
         if (rea) begin n_rea++; cid = chain_id; end
         if (wea && rea) both = 1'b1;
         if ((ack | nack) != '0 || free_ack) begin lat = i; break; end
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1; req = '0; req_size = '0; free_req = 1'b0; free_id = '0; free_size = '0;
      swa = '0; sra = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++; if ({ack, nack, free_ack, wea, rea, busy} !== '0)
         $display("FAIL reset_ctrl got=%b exp=0", {ack, nack, free_ack, wea, rea, busy}); else n_pass++;
      n_checks++; if ({w_size, chain_id, rsp_addr, free_addr} !== '0)
         $display("FAIL reset_data got=%h exp=0", {w_size, chain_id, rsp_addr, free_addr}); else n_pass++;
      n_checks++; if (free_units !== 13'd4096)
         $display("FAIL reset_units got=%0d exp=4096", free_units); else n_pass++;
      rst = 1'b0;
      exp_units = 13'd4096;
   endtask

   task automatic test_single_alloc();
      int lat, nw, nr; logic [7:0] wsz; logic [11:0] cid; logic both; exp_t e;
      @(negedge clk);
      swa = 12'h000; req_size[7:0] = 8'd16; req = 4'b0001;
      exp_units = exp_units - 13'd16;
      sb.push_back('{0, 0, 12'h000, exp_units});
      observe(10, lat, nw, nr, wsz, cid, both);
      e = sb.pop_front();
      n_checks++; if (lat !== 4) $display("FAIL single_latency got=%0d exp=4", lat); else n_pass++;
      n_checks++; if (nw !== 1 || wsz !== 8'd16)
         $display("FAIL single_wea got=%0d/%0d exp=1/16", nw, wsz); else n_pass++;
      n_checks++; if ({ack, nack, free_ack} !== exp_vec(e.kind, e.port))
         $display("FAIL single_resp got=%b exp=%b", {ack, nack, free_ack}, exp_vec(e.kind, e.port)); else n_pass++;
      n_checks++; if (rsp_addr !== e.addr) $display("FAIL single_addr got=%h exp=%h", rsp_addr, e.addr); else n_pass++;
      n_checks++; if (free_units !== e.units) $display("FAIL single_units got=%0d exp=%0d", free_units, e.units); else n_pass++;
      @(posedge clk); #1;
      req[0] = 1'b0;
   endtask

   task automatic test_back_to_back();
      int lat, nw, nr; logic [7:0] wsz; logic [11:0] cid; logic both; exp_t e;
      int order[5] = '{0, 1, 2, 3, 0};
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      exp_units = 13'd4096;
      swa = 12'h0A5;
      req_size = {8'd1, 8'd1, 8'd1, 8'd1};
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         exp_units = exp_units - 13'd1;
         sb.push_back('{0, order[k], 12'h0A5, exp_units});
      end
      for (int k = 0; k < 5; k++) begin
         observe(8, lat, nw, nr, wsz, cid, both);
         e = sb.pop_front();
         n_checks++; if (lat !== 4) $display("FAIL b2b_latency[%0d] got=%0d exp=4", k, lat); else n_pass++;
         n_checks++; if ({ack, nack, free_ack} !== exp_vec(e.kind, e.port))
            $display("FAIL b2b_resp[%0d] got=%b exp=%b", k, {ack, nack, free_ack}, exp_vec(e.kind, e.port)); else n_pass++;
         n_checks++; if (rsp_addr !== e.addr || free_units !== e.units)
            $display("FAIL b2b_data[%0d] got=%h/%0d exp=%h/%0d", k, rsp_addr, free_units, e.addr, e.units); else n_pass++;
         n_checks++; if (nw !== 1 || nr !== 0)
            $display("FAIL b2b_strobes[%0d] got=%0d/%0d exp=1/0", k, nw, nr); else n_pass++;
         @(posedge clk); #1;
         req[e.port] = 1'b0;
         if (k == 1) req[0] = 1'b1;
      end
   endtask

   task automatic test_zero_size();
      int lat, nw, nr; logic [7:0] wsz; logic [11:0] cid; logic both; exp_t e;
      @(negedge clk);
      req_size[23:16] = 8'd0; req = 4'b0100;
      sb.push_back('{1, 2, 12'h000, exp_units});
      observe(4, lat, nw, nr, wsz, cid, both);
      e = sb.pop_front();
      n_checks++; if (lat !== 1) $display("FAIL zero_latency got=%0d exp=1", lat); else n_pass++;
      n_checks++; if ({ack, nack, free_ack} !== exp_vec(e.kind, e.port))
         $display("FAIL zero_resp got=%b exp=%b", {ack, nack, free_ack}, exp_vec(e.kind, e.port)); else n_pass++;
      n_checks++; if (nw !== 0 || free_units !== e.units)
         $display("FAIL zero_side got=%0d/%0d exp=0/%0d", nw, free_units, e.units); else n_pass++;
      @(posedge clk); #1;
      req[2] = 1'b0;
   endtask

   task automatic test_oversize();
      int lat, nw, nr; logic [7:0] wsz; logic [11:0] cid; logic both; exp_t e;
      logic [12:0] sz;
      while (exp_units > 13'd10) begin
         @(negedge clk);
         sz = ((exp_units - 13'd10) > 13'd255) ? 13'd255 : (exp_units - 13'd10);
         req_size[31:24] = sz[7:0]; swa = 12'h300 + 12'(sz); req = 4'b1000;
         exp_units = exp_units - sz;
         sb.push_back('{0, 3, 12'h300 + 12'(sz), exp_units});
         observe(8, lat, nw, nr, wsz, cid, both);
         e = sb.pop_front();
         n_checks++; if ({ack, nack, free_ack} !== exp_vec(e.kind, e.port) || rsp_addr !== e.addr || free_units !== e.units)
            $display("FAIL fill got=%b/%h/%0d exp=%b/%h/%0d", {ack, nack, free_ack}, rsp_addr, free_units,
                     exp_vec(e.kind, e.port), e.addr, e.units); else n_pass++;
         @(posedge clk); #1;
         req[3] = 1'b0;
      end
      @(negedge clk);
      req_size[15:8] = 8'd20; req = 4'b0010;
      sb.push_back('{1, 1, 12'h000, exp_units});
      observe(4, lat, nw, nr, wsz, cid, both);
      e = sb.pop_front();
      n_checks++; if ({ack, nack, free_ack} !== exp_vec(e.kind, e.port) || lat !== 1)
         $display("FAIL oversize_resp got=%b/%0d exp=%b/1", {ack, nack, free_ack}, lat, exp_vec(e.kind, e.port)); else n_pass++;
      n_checks++; if (nw !== 0 || free_units !== 13'd10)
         $display("FAIL oversize_side got=%0d/%0d exp=0/10", nw, free_units); else n_pass++;
      @(posedge clk); #1;
      req[1] = 1'b0;
   endtask

   task automatic test_free();
      int lat, nw, nr; logic [7:0] wsz; logic [11:0] cid; logic both; exp_t e;
      @(negedge clk);
      free_id = 12'd3; free_size = 8'd20; sra = 12'h040; free_req = 1'b1;
      exp_units = exp_units + 13'd20;
      sb.push_back('{2, 0, 12'h040, exp_units});
      observe(8, lat, nw, nr, wsz, cid, both);
      e = sb.pop_front();
      n_checks++; if (lat !== 4) $display("FAIL free_latency got=%0d exp=4", lat); else n_pass++;
      n_checks++; if (nr !== 1 || cid !== 12'd3 || nw !== 0)
         $display("FAIL free_rea got=%0d/%0d/%0d exp=1/3/0", nr, cid, nw); else n_pass++;
      n_checks++; if ({ack, nack, free_ack} !== exp_vec(e.kind, e.port))
         $display("FAIL free_resp got=%b exp=%b", {ack, nack, free_ack}, exp_vec(e.kind, e.port)); else n_pass++;
      n_checks++; if (free_addr !== e.addr || free_units !== e.units)
         $display("FAIL free_data got=%h/%0d exp=%h/%0d", free_addr, free_units, e.addr, e.units); else n_pass++;
      @(posedge clk); #1;
      free_req = 1'b0;
   endtask

   task automatic test_priority();
      int lat, nw, nr; logic [7:0] wsz; logic [11:0] cid; logic both; exp_t e;
      @(negedge clk);
      req_size[7:0] = 8'd7; swa = 12'h0AB;
      free_id = 12'd9; free_size = 8'd5; sra = 12'h077;
      req = 4'b0001; free_req = 1'b1;
`ifdef CHAIN_ARB_FREE_PRIORITY_EN
      sb.push_back('{2, 0, 12'h077, exp_units + 13'd5});
      sb.push_back('{0, 0, 12'h0AB, exp_units - 13'd2});
`else
      sb.push_back('{0, 0, 12'h0AB, exp_units - 13'd7});
      sb.push_back('{2, 0, 12'h077, exp_units - 13'd2});
`endif
      exp_units = exp_units - 13'd2;
      for (int k = 0; k < 2; k++) begin
         observe(10, lat, nw, nr, wsz, cid, both);
         e = sb.pop_front();
         n_checks++; if ({ack, nack, free_ack} !== exp_vec(e.kind, e.port))
            $display("FAIL prio_order[%0d] got=%b exp=%b", k, {ack, nack, free_ack}, exp_vec(e.kind, e.port)); else n_pass++;
         n_checks++; if (((e.kind == 0) ? rsp_addr : free_addr) !== e.addr || free_units !== e.units)
            $display("FAIL prio_data[%0d] got=%h/%h/%0d exp=%h/%0d", k, rsp_addr, free_addr, free_units, e.addr, e.units); else n_pass++;
         n_checks++; if (both !== 1'b0 || (nw + nr) !== 1)
            $display("FAIL prio_strobes[%0d] got=%0d/%0d/%b exp=one strobe", k, nw, nr, both); else n_pass++;
         @(posedge clk); #1;
         if (e.kind == 0) req[0] = 1'b0;
         else free_req = 1'b0;
      end
   endtask

   task automatic test_reset_midflight();
      int lat, nw, nr; logic [7:0] wsz; logic [11:0] cid; logic both;
      @(negedge clk);
      req_size[15:8] = 8'd4; swa = 12'h222; req = 4'b0010;
      @(negedge clk);
      n_checks++; if (wea !== 1'b1) $display("FAIL mid_issue got=%b exp=1", wea); else n_pass++;
      @(negedge clk);
      n_checks++; if (busy !== 1'b1 || wea !== 1'b0) $display("FAIL mid_capt got=%b/%b exp=1/0", busy, wea); else n_pass++;
      rst = 1'b1; req = '0;
      @(negedge clk);
      n_checks++; if ({ack, nack, free_ack, wea, rea, busy} !== '0 || {w_size, chain_id, rsp_addr, free_addr} !== '0)
         $display("FAIL mid_reset got=%b/%h exp=0/0", {ack, nack, free_ack, wea, rea, busy},
                  {w_size, chain_id, rsp_addr, free_addr}); else n_pass++;
      n_checks++; if (free_units !== 13'd4096) $display("FAIL mid_units got=%0d exp=4096", free_units); else n_pass++;
      rst = 1'b0;
      exp_units = 13'd4096;
      observe(8, lat, nw, nr, wsz, cid, both);
      n_checks++; if (lat !== -1 || nw !== 0) $display("FAIL mid_no_ack got=%0d/%0d exp=-1/0", lat, nw); else n_pass++;
   endtask

   task automatic test_saturate();
      int lat, nw, nr; logic [7:0] wsz; logic [11:0] cid; logic both; exp_t e;
      @(negedge clk);
      free_id = 12'd5; free_size = 8'd10; sra = 12'h123; free_req = 1'b1;
      sb.push_back('{2, 0, 12'h123, 13'd4096});
      observe(8, lat, nw, nr, wsz, cid, both);
      e = sb.pop_front();
      n_checks++; if ({ack, nack, free_ack} !== exp_vec(e.kind, e.port) || free_addr !== e.addr)
         $display("FAIL sat_resp got=%b/%h exp=%b/%h", {ack, nack, free_ack}, free_addr, exp_vec(e.kind, e.port), e.addr); else n_pass++;
      n_checks++; if (free_units !== e.units) $display("FAIL sat_units got=%0d exp=%0d", free_units, e.units); else n_pass++;
      @(posedge clk); #1;
      free_req = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_alloc();
      test_back_to_back();
      test_zero_size();
      test_oversize();
      test_free();
      test_priority();
      test_reset_midflight();
      test_saturate();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/chain_alloc_arbiter.md
Name: chain_alloc_arbiter

Overview:
- Shares one chain-list memory allocator between NUM_PORTS allocation requesters and one release (free) requester.
- Serialises requests onto the allocator's wea/w_size and rea/chain_id strobes, captures the returned start addresses and acknowledges the winning requester.
- Keeps a running count of free 64-byte units, so oversize and zero-size requests are rejected before they reach the allocator.

Parameters:
NUM_PORTS, 4, number of allocation requesters (2..8)
CAPACITY, 4096, total allocatable units; free_units reset value

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req  in  NUM_PORTS  per-port allocation request, level, held until ack/nack
req_size  in  NUM_PORTS*8  per-port requested size; port p uses bits [8p+7:8p]
ack  out  NUM_PORTS  one-hot, 1-cycle pulse: allocation done
nack  out  NUM_PORTS  one-hot, 1-cycle pulse: request rejected
rsp_addr  out  12  start address; valid only while the matching ack bit is high
free_req  in  1  release request, level, held until free_ack
free_id  in  12  chain node id to release
free_size  in  8  size of block being released
free_ack  out  1  1-cycle pulse: release done
free_addr  out  12  start address of released block; valid while free_ack is high
wea  out  1  to allocator: write (allocate) strobe
w_size  out  8  to allocator: allocation size
start_write_address  in  12  from allocator
rea  out  1  to allocator: read/release strobe
chain_id  out  12  to allocator: node to release
start_read_address  in  12  from allocator
free_units  out  13  unallocated units
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE; ack, nack, free_ack, wea, rea, busy = 0.
  - w_size, chain_id, rsp_addr, free_addr = 0.
  - free_units = CAPACITY; rr_ptr = 0.
  - Any transaction in flight is abandoned without ack; requesters re-request.
- FSM states: IDLE, ISSUE_A, CAPT_A, RESP_A, ISSUE_F, CAPT_F, RESP_F.
- IDLE, when free_req=1 and the free-priority rule selects it (see Optional Feature):
  - Latch free_id and free_size; go to ISSUE_F.
- IDLE, otherwise, when any req bit is set:
  - Grant the first set bit searching from rr_ptr upward with wrap-around.
  - If the granted size is 0, or size > free_units: assert nack[g] for 1 cycle next cycle, stay in IDLE, allocator is not touched.
  - Otherwise latch g and size; go to ISSUE_A.
- ISSUE_A: wea=1 and w_size=latched size for exactly one cycle; go to CAPT_A.
- CAPT_A: register start_write_address into rsp_addr; free_units -= size; go to RESP_A.
- RESP_A: ack[g]=1 for one cycle; rr_ptr = (g+1) mod NUM_PORTS; go to IDLE.
- ISSUE_F: rea=1 and chain_id=latched id for one cycle; go to CAPT_F.
- CAPT_F:
  - Register start_read_address into free_addr.
  - free_units += free_size, saturating at CAPACITY.
  - Go to RESP_F.
- RESP_F: free_ack=1 for one cycle; go to IDLE.
- Latency:
  - Accepted allocation: 4 cycles from the IDLE cycle that samples req to the ack pulse.
  - Release: 4 cycles to free_ack.
  - nack: 1 cycle.
- Requester protocol:
  - A requester drops req in the cycle after ack/nack.
  - The arbiter ignores a req bit during its own ack/nack cycle; it is not re-granted that cycle.
- wea and rea are never high in the same cycle; at most one is high per transaction.
- nack of port g also advances rr_ptr to g+1, so a rejected port cannot block the others.
- free_units never underflows: the reject check guarantees size <= free_units.
- A simultaneous free and alloc in IDLE resolve per the priority rule; the loser waits and keeps its request.

Optional Feature:
- Macro: CHAIN_ARB_FREE_PRIORITY_EN.
- Defined: free_req always wins in IDLE over any req; releases never wait behind allocations.
- Undefined: a toggle bit alternates priority.
  - After an alloc or nack, free wins next time both are pending.
  - After a free, alloc wins next time both are pending.
  - The toggle resets to "free wins".

Test Plan:
- Reset, then req=4'b0001 with size 8'd16 and allocator returning 12'h000:
  - wea high exactly 1 cycle with w_size=16.
  - ack=4'b0001 with rsp_addr=12'h000, 4 cycles after the req sample.
  - free_units=4080.
- req=4'b1111 held, all sizes 8'd1:
  - Acks in order port0, 1, 2, 3, then port0 again (if re-requested), each 4 cycles apart.
  - Never two ack bits high together.
- req_size=0 on port2: nack=4'b0100 one cycle later; wea stays 0; free_units unchanged.
- Force free_units=10 via allocations, then request 8'd20 on port1: nack[1]=1 and no wea.
- Then free_req with free_id=12'd3, free_size=8'd20, start_read_address=12'h040:
  - rea 1 cycle with chain_id=3.
  - free_ack with free_addr=12'h040; free_units=30.
- free_req and req[0] asserted in the same cycle:
  - With the macro defined, free completes first.
  - Undefined after a prior free, alloc completes first.
- Assert rst during CAPT_A: all outputs reach reset values next cycle, no ack is issued, free_units=4096.
